multi_channel_go_fsm: RTL and testbench

- Parametrised, registered successor of the single-channel IDLE/ACTIVE "go" state machine.
- Each of CHANNELS independent channels tracks its own "go" input.
- Adds, per channel:
  - arm qualification: go must stay high N cycles before the channel goes ACTIVE;
  - release hold-off: go must stay low M cycles before the channel drops;
  - an optional active-duration timeout that latches a fault.
- Sits between raw request lines and downstream consumers that need clean, glitch-filtered active flags plus an aggregate busy count.

---
 rtl/multi_channel_go_fsm.sv | 133 +++++++++++++
 tb/tb_multi_channel_go_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multi_channel_go_fsm.sv
// multi_channel_go_fsm: per-channel glitch-filtered go tracker with arm/hold qualification and active timeout.
module multi_channel_go_fsm #(
    parameter int CHANNELS       = 4,
    parameter int ARM_CYCLES     = 2,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [CHANNELS-1:0]                go,
    output logic [CHANNELS-1:0]                state,
    output logic [CHANNELS-1:0]                rise,
    output logic [CHANNELS-1:0]                fault,
    output logic [$clog2(CHANNELS+1)-1:0]      active_count
);
    typedef enum logic [2:0] {IDLE, ARM, ACTIVE, HOLD, FAULT} st_t;

    st_t                 st_q  [CHANNELS];
    st_t                 st_d  [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CNT_W-1:0]    tmr_q [CHANNELS];
    logic [CNT_W-1:0]    tmr_d [CHANNELS];
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
                tmr_q[i] <= '0;
            end
            rise_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                tmr_q[i] <= tmr_d[i];
            end
            rise_q <= rise_d;
        end
    end

    always_comb begin
        rise_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            tmr_d[i] = tmr_q[i];
            if (clear) begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
                tmr_d[i] = '0;
            end else if (TIMEOUT_CYCLES > 0 && (st_q[i] == ACTIVE || st_q[i] == HOLD) &&
                         tmr_q[i] == CNT_W'(TIMEOUT_CYCLES)) begin
                st_d[i]  = FAULT;
                cnt_d[i] = '0;
                tmr_d[i] = '0;
            end else begin
                case (st_q[i])
                    IDLE: begin
                        if (go[i] && ARM_CYCLES == 1) begin
                            st_d[i]   = ACTIVE;
                            tmr_d[i]  = CNT_W'(1);
                            rise_d[i] = 1'b1;
                        end else if (go[i]) begin
                            st_d[i]  = ARM;
                            cnt_d[i] = CNT_W'(1);
                        end
                    end
                    ARM: begin
                        if (!go[i]) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] + CNT_W'(1) == CNT_W'(ARM_CYCLES)) begin
                            st_d[i]   = ACTIVE;
                            cnt_d[i]  = '0;
                            tmr_d[i]  = CNT_W'(1);
                            rise_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    ACTIVE: begin
                        tmr_d[i] = (tmr_q[i] < CNT_W'(TIMEOUT_CYCLES)) ? tmr_q[i] + CNT_W'(1) : tmr_q[i];
                        if (!go[i] && HOLD_CYCLES == 1) begin
                            st_d[i]  = IDLE;
                            tmr_d[i] = '0;
                        end else if (!go[i]) begin
                            st_d[i]  = HOLD;
                            cnt_d[i] = CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        tmr_d[i] = (tmr_q[i] < CNT_W'(TIMEOUT_CYCLES)) ? tmr_q[i] + CNT_W'(1) : tmr_q[i];
                        if (go[i]) begin
                            st_d[i]  = ACTIVE;
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] + CNT_W'(1) == CNT_W'(HOLD_CYCLES)) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                            tmr_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    FAULT: st_d[i] = go[i] ? FAULT : IDLE;
                    default: begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                        tmr_d[i] = '0;
                    end
                endcase
            end
            // With timeout disabled the timer never leaves zero.
            if (TIMEOUT_CYCLES == 0) tmr_d[i] = '0;
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state[i]     = (st_q[i] == ACTIVE) || (st_q[i] == HOLD);
            fault[i]     = (st_q[i] == FAULT);
            active_count = active_count + ($clog2(CHANNELS+1))'(state[i]);
        end
    end

    assign rise = rise_q;
endmodule

// File: tb/tb_multi_channel_go_fsm.sv
// tb_multi_channel_go_fsm: directed checks of arm/hold filtering, timeout, clear, async reset and a degenerate config.
module tb_multi_channel_go_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] go = '0;
    logic [3:0] go_d = '0;
    logic [3:0] state, rise, fault, state_d, rise_d, fault_d;
    logic [2:0] active_count, active_count_d;
    int         n_chk = 0;
    int         n_fail = 0;

    multi_channel_go_fsm dut (
        .clk(clk), .reset(reset), .clear(clear), .go(go),
        .state(state), .rise(rise), .fault(fault), .active_count(active_count)
    );

    multi_channel_go_fsm #(.ARM_CYCLES(1), .HOLD_CYCLES(1), .TIMEOUT_CYCLES(0)) dut_dg (
        .clk(clk), .reset(reset), .clear(clear), .go(go_d),
        .state(state_d), .rise(rise_d), .fault(fault_d), .active_count(active_count_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int highs;
        int first_fault;
        step();
        step();
        chk("reset_state", state, 4'h0);
        chk("reset_rise", rise, 4'h0);
        chk("reset_fault", fault, 4'h0);
        chk("reset_count", active_count, 3'd0);
        reset = 1'b0;
        // arm filter: single high sample is rejected
        go = 4'b0001;
        step();
        go = 4'b0000;
        step();
        chk("arm_glitch_a", state, 4'h0);
        step();
        chk("arm_glitch_b", state, 4'h0);
        go = 4'b0001;
        step();
        chk("arm_first", state, 4'h0);
        step();
        chk("arm_state", state, 4'h1);
        chk("arm_rise", rise, 4'h1);
        chk("arm_count", active_count, 3'd1);
        step();
        chk("arm_rise_clr", rise, 4'h0);
        chk("arm_hold_st", state, 4'h1);
        // hold-off: 2 lows then high keeps channel up
        go = 4'b0000;
        step();
        chk("hold_1", state, 4'h1);
        step();
        chk("hold_2", state, 4'h1);
        go = 4'b0001;
        step();
        chk("hold_back", state, 4'h1);
        chk("hold_no_rise", rise, 4'h0);
        go = 4'b0000;
        step();
        chk("drop_1", state, 4'h1);
        step();
        chk("drop_2", state, 4'h1);
        step();
        chk("drop_3", state, 4'h0);
        chk("drop_count", active_count, 3'd0);
        // timeout on channel 1
        go = 4'b0010;
        highs = 0;
        first_fault = 0;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (state[1]) highs++;
            if (fault[1] && first_fault == 0) first_fault = s;
        end
        chk("to_highs", highs, 10);
        chk("to_fault_step", first_fault, 12);
        chk("to_fault", fault, 4'b0010);
        chk("to_state", state, 4'h0);
        go = 4'b0000;
        step();
        chk("to_exit", fault, 4'h0);
        go = 4'b0010;
        step();
        chk("rearm_1", state, 4'h0);
        step();
        chk("rearm_2", state, 4'b0010);
        chk("rearm_rise", rise, 4'b0010);
        go = 4'b0000;
        step();
        step();
        step();
        chk("rearm_drop", state, 4'h0);
        // all channels together, then clear
        go = 4'b1111;
        step();
        step();
        chk("all_state", state, 4'hf);
        chk("all_count", active_count, 3'd4);
        chk("all_rise", rise, 4'hf);
        step();
        chk("all_rise_clr", rise, 4'h0);
        clear = 1'b1;
        step();
        chk("clear_state", state, 4'h0);
        chk("clear_count", active_count, 3'd0);
        clear = 1'b0;
        go = 4'b0000;
        step();
        // async reset while channel 2 is in HOLD
        go = 4'b0100;
        step();
        step();
        chk("ar_active", rise, 4'b0100);
        go = 4'b0000;
        step();
        chk("ar_hold", state, 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("ar_state", state, 4'h0);
        chk("ar_rise", rise, 4'h0);
        chk("ar_fault", fault, 4'h0);
        go = 4'b0100;
        step();
        reset = 1'b0;
        step();
        chk("ar_rearm_1", state, 4'h0);
        chk("ar_no_pulse", rise, 4'h0);
        step();
        chk("ar_rearm_2", state, 4'b0100);
        go = 4'b0000;
        // degenerate instance follows go by one clock, never faults
        for (int s = 0; s < 100; s++) begin
            go_d = 4'($urandom_range(0, 15));
            step();
            chk("dg_state", state_d, go_d);
            chk("dg_count", active_count_d, $countones(go_d));
            chk("dg_fault", fault_d, 4'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
